// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block widths, the arbiter FSM state enum and the
// forward S-box used by the SubWord unit.
package aes_pkg;

   localparam int WORD_W        = 32;
   localparam int BLK_W         = 128;
   localparam int WORDS_PER_BLK = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      KEY_WAIT  = 2'd1,
      BLK_ISSUE = 2'd2,
      BLK_DRAIN = 2'd3
   } arb_state_e;

   typedef enum logic {
      GRANT_KEY = 1'b0,
      GRANT_BLK = 1'b1
   } grant_e;

   // Row r holds S(r0..rF); element 0 is the leftmost byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/subword2.sv
// Registered SubWord unit: four parallel S-boxes, result one cycle after the
// operand is presented.
module subword2
   import aes_pkg::*;
(
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);

   always_ff @(posedge sys_clk) begin
      if (rst) dout <= '0;
      else     dout <= sub_word(din);
   end

endmodule

// File: rtl/subword_arbiter.sv
// Time-shares one SubWord unit between a key-expansion and a cipher-round requester.
// Define SUBWORD_ARB_FIXED_PRIO_EN to give key requests strict priority on ties.
module subword_arbiter
   import aes_pkg::*;
(
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic [WORD_W-1:0] key_word,
   output logic              key_ready,
   output logic              key_resp_valid,
   output logic [WORD_W-1:0] key_resp_word,
   input  logic              blk_valid,
   input  logic [BLK_W-1:0]  blk_state,
   output logic              blk_ready,
   output logic              blk_resp_valid,
   output logic [BLK_W-1:0]  blk_resp_state,
   output logic              busy
);

   localparam int         ACC_W    = BLK_W - WORD_W;
   localparam logic [1:0] LAST_CNT = 2'(WORDS_PER_BLK - 1);

   arb_state_e        state_q, state_d;
   logic [1:0]        cnt_q;
   logic [BLK_W-1:0]  hold_q;
   logic [ACC_W-1:0]  acc_q;
   logic [WORD_W-1:0] unit_in, unit_out;
   logic              in_idle, key_win, key_grant, blk_grant;

   // Handshakes: a request is accepted in the cycle where valid and ready are
   // both high; ready only rises in IDLE, responses are single-cycle pulses.
   assign in_idle   = !rst && (state_q == IDLE);
   assign key_grant = in_idle && key_valid && (!blk_valid || key_win);
   assign blk_grant = in_idle && blk_valid && !key_grant;

`ifdef SUBWORD_ARB_FIXED_PRIO_EN
   assign key_win = 1'b1;
`else
   grant_e last_grant_q;

   always_ff @(posedge sys_clk) begin
      if (rst)            last_grant_q <= GRANT_BLK;
      else if (key_grant) last_grant_q <= GRANT_KEY;
      else if (blk_grant) last_grant_q <= GRANT_BLK;
   end

   assign key_win = (last_grant_q == GRANT_BLK);
`endif

   always_ff @(posedge sys_clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (key_grant)      state_d = KEY_WAIT;
            else if (blk_grant) state_d = BLK_ISSUE;
         end
         KEY_WAIT:  state_d = IDLE;
         BLK_ISSUE: if (cnt_q == LAST_CNT) state_d = BLK_DRAIN;
         BLK_DRAIN: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Unit output for hold word cnt-1 arrives while cnt is being issued.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         cnt_q  <= '0;
         hold_q <= '0;
         acc_q  <= '0;
      end else begin
         if (blk_grant) begin
            hold_q <= blk_state;
            acc_q  <= '0;
         end
         if (state_q == BLK_ISSUE) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q != 2'd0) acc_q <= {acc_q[ACC_W-WORD_W-1:0], unit_out};
         end
      end
   end

   always_comb begin
      unit_in        = '0;
      key_ready      = key_grant;
      blk_ready      = blk_grant;
      busy           = !rst && (state_q != IDLE);
      key_resp_valid = !rst && (state_q == KEY_WAIT);
      blk_resp_valid = !rst && (state_q == BLK_DRAIN);
      key_resp_word  = key_resp_valid ? unit_out : '0;
      blk_resp_state = blk_resp_valid ? {acc_q, unit_out} : '0;
      case (state_q)
         IDLE: unit_in = key_word;
         BLK_ISSUE: begin
            case (cnt_q)
               2'd0:    unit_in = hold_q[BLK_W-1 -: WORD_W];
               2'd1:    unit_in = hold_q[BLK_W-1-WORD_W -: WORD_W];
               2'd2:    unit_in = hold_q[BLK_W-1-2*WORD_W -: WORD_W];
               default: unit_in = hold_q[WORD_W-1:0];
            endcase
         end
         default: unit_in = '0;
      endcase
   end

   subword2 u_subword2 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .din     (unit_in),
      .dout    (unit_out)
   );

endmodule

// File: doc/subword_arbiter.md
SUBWORD_ARBITER -- requirements
Module: subword_arbiter

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: single clock; every register updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port key_valid, input, 1 bit: the key-expansion requester has a word to substitute.
REQ-004 SHALL have port key_word, input, 32 bits: key-expansion operand, held stable while key_valid is high.
REQ-005 SHALL have port key_ready, output, 1 bit: key request accepted this cycle.
REQ-006 SHALL have port key_resp_valid, output, 1 bit: one-cycle pulse marking key_resp_word valid.
REQ-007 SHALL have port key_resp_word, output, 32 bits: substituted key word.
REQ-008 SHALL have port blk_valid, input, 1 bit: the cipher-round requester has a 128-bit state to substitute.
REQ-009 SHALL have port blk_state, input, 128 bits: cipher state, held stable while blk_valid is high.
REQ-010 SHALL have port blk_ready, output, 1 bit: block request accepted this cycle.
REQ-011 SHALL have port blk_resp_valid, output, 1 bit: one-cycle pulse marking blk_resp_state valid.
REQ-012 SHALL have port blk_resp_state, output, 128 bits: SubBytes result.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL time-share one registered 32-bit SubWord unit (4 S-boxes, 1-cycle latency) between the two requesters.
REQ-015 SHALL use FSM states IDLE, KEY_WAIT, BLK_ISSUE, BLK_DRAIN, and SHALL make grants only in IDLE.
REQ-016 SHALL complete a key handshake at cycle T when key_valid and key_ready are both high in IDLE. key_word drives the unit at T. The FSM moves to KEY_WAIT. At T+1: key_resp_valid=1, key_resp_word=unit output, then return to IDLE.
REQ-017 SHALL complete a block handshake at cycle T when blk_valid and blk_ready are both high in IDLE, and SHALL latch blk_state into a hold register at T.
REQ-018 SHALL, in BLK_ISSUE, drive hold word cnt (2-bit cnt, 0..3; word 0 = bits 127:96) into the unit during T+1..T+4.
REQ-019 SHALL accumulate unit outputs into a 128-bit result in word order.
REQ-020 SHALL enter BLK_DRAIN when cnt wraps from 3 to 0.
REQ-021 SHALL, at T+5 (BLK_DRAIN), assert blk_resp_valid=1 with blk_resp_state = {three accumulated words, unit output}, then return to IDLE.
REQ-022 SHALL accept the next request no earlier than T+2 after a key grant and T+6 after a block grant.
REQ-023 SHALL never assert key_ready and blk_ready in the same cycle, and SHALL hold both low outside IDLE.
REQ-024 SHALL arbitrate as follows:
- a lone request is granted immediately;
- when both requests are present, the requester not granted last wins (round-robin);
- a last_grant register records the winner and resets to "block", so key wins the first tie.
REQ-025 SHALL drive key_resp_word and blk_resp_state to 0 whenever the matching resp_valid is low.
REQ-026 SHALL give responses no backpressure; requesters must sample in the valid cycle.
REQ-027 SHALL ignore a requester that drops valid before its grant; nothing is latched for it.

Reset
REQ-028 SHALL, on rst, set state=IDLE, cnt=0, last_grant=block, accumulator=0, and all ready/resp_valid/busy/resp data outputs=0.
REQ-029 SHALL, when rst is asserted mid-transaction, abandon the transaction with no response, including when rst hits in the same cycle the response would fire.
REQ-030 SHALL accept a grant on the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, when SUBWORD_ARB_FIXED_PRIO_EN is defined, give key requests strict priority on ties, and last_grant SHALL be neither updated nor used.
REQ-032 SHALL, when SUBWORD_ARB_FIXED_PRIO_EN is undefined, use the round-robin of REQ-024.

Structure
REQ-033 SHALL take the FSM state enum, WORD_W=32, BLK_W=128 and WORDS_PER_BLK=4 from the shared package aes_pkg.
REQ-034 SHALL instantiate exactly one SubWord2 as its only sub-module.
REQ-035 SHALL use a unit-input mux driven by state: key_word in IDLE, hold word cnt in BLK_ISSUE, 0 otherwise.

Verification
REQ-036 SHALL cover: key_word=0x00000000 granted at T -> key_resp_valid at T+1, key_resp_word=0x63636363.
REQ-037 SHALL cover: blk_state=0x00112233_44556677_8899AABB_CCDDEEFF granted at T -> blk_resp_valid only at T+5, value 0x638293C3_1BFC33F5_C4EEACEA_4BC12816; busy high T+1..T+5.
REQ-038 SHALL cover: key and blk requests held continuously from reset -> grants alternate key, blk, key, blk; with SUBWORD_ARB_FIXED_PRIO_EN -> key granted every time it is IDLE-eligible and blk is starved.
REQ-039 SHALL cover: key request raised during BLK_ISSUE -> key_ready low until IDLE; key granted at T+6, key_resp_valid at T+7.
REQ-040 SHALL cover: rst pulsed at T+3 of a block transaction -> no blk_resp_valid; outputs 0; a new key_word=0x53535353 granted after reset returns 0xEDEDEDED.
REQ-041 SHALL cover: key_valid dropped in the cycle before its grant -> no key_ready and no key_resp_valid.
